// File: rtl/hex_msg_pkg.sv
// Shared segment codes and output helpers for the scrolling HEX message display.
// Segment codes are active-high, bit0 = segment a.
package hex_msg_pkg;

    localparam logic [6:0] SEG_H     = 7'h76;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_L     = 7'h38;
    localparam logic [6:0] SEG_O     = 7'h3F;
    localparam logic [6:0] SEG_U     = 7'h3E;
    localparam logic [6:0] SEG_R     = 7'h50;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Pin-level value of one dark digit, which depends on the board's output polarity.
    function automatic logic [6:0] seg_blank_out(input bit active_low);
        return active_low ? ~SEG_BLANK : SEG_BLANK;
    endfunction

endpackage

// File: rtl/hex_scroll_tick.sv
// Scroll-rate prescaler: raises step for one cycle every TICK_DIV enabled cycles.
// step is taken straight from the counter so the position moves on the terminal-count edge.
module hex_scroll_tick
    import hex_msg_pkg::*;
#(
    parameter int TICK_DIV = 12500000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic pause,
    output logic step
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    // Disabling clears the count, pausing only freezes it; pause is ignored while disabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (!en) begin
            count <= '0;
        end else if (!pause) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

    always_comb begin
        step = en && !pause && (count == LAST);
    end

endmodule

// File: rtl/hex_msg_scroller.sv
// Writable message buffer of segment codes scrolled across NUM_DIGITS HEX displays.
// Digit 0 (leftmost) is in the MSBs of hex_out; the message repeats when shorter than the display.
module hex_msg_scroller
    import hex_msg_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int MSG_DEPTH  = 16,
    parameter int TICK_DIV   = 12500000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic                         pause,
    input  logic                         dir,
    input  logic [$clog2(MSG_DEPTH):0]   msg_len,
    input  logic                         wr_en,
    input  logic [$clog2(MSG_DEPTH)-1:0] wr_addr,
    input  logic [6:0]                   wr_data,
    output logic [7*NUM_DIGITS-1:0]      hex_out,
    output logic                         wrap
);

    localparam int AW = $clog2(MSG_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [7*NUM_DIGITS-1:0] BLANK_OUT = {NUM_DIGITS{seg_blank_out(ACTIVE_LOW != 0)}};

    logic [6:0]              msg [MSG_DEPTH];
    logic [LW-1:0]           len;
    logic [AW-1:0]           pos;
    logic                    step;
    logic [AW-1:0]           cur;
    logic [6:0]              seg;
    logic [7*NUM_DIGITS-1:0] hex_next;

    hex_scroll_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .pause (pause),
        .step  (step)
    );

    always_comb begin
        len = (msg_len > LW'(MSG_DEPTH)) ? LW'(MSG_DEPTH) : msg_len;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MSG_DEPTH; i++) begin
                msg[i] <= SEG_BLANK;
            end
        end else if (wr_en) begin
            msg[wr_addr] <= wr_data;
        end
    end

    // An out-of-range position (shrunk or zero length) snaps to 0 silently and beats any step.
    always_ff @(posedge clk) begin
        if (reset) begin
            pos  <= '0;
            wrap <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if ({1'b0, pos} >= len) begin
                pos <= '0;
            end else if (step) begin
                if (!dir) begin
                    if ({1'b0, pos} == len - LW'(1)) begin
                        pos  <= '0;
                        wrap <= 1'b1;
                    end else begin
                        pos <= pos + AW'(1);
                    end
                end else begin
                    if (pos == '0) begin
                        pos  <= AW'(len - LW'(1));
                        wrap <= 1'b1;
                    end else begin
                        pos <= pos - AW'(1);
                    end
                end
            end
        end
    end

    // Walk the buffer from pos, wrapping at msg_len, to pick each digit's code.
    always_comb begin
        hex_next = BLANK_OUT;
        cur      = pos;
        seg      = SEG_BLANK;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            seg = (len == '0) ? SEG_BLANK : msg[cur];
            hex_next[(NUM_DIGITS-1-k)*7 +: 7] = (ACTIVE_LOW != 0) ? ~seg : seg;
            cur = (({1'b0, cur} + LW'(1)) == len) ? '0 : cur + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hex_out <= BLANK_OUT;
        end else begin
            hex_out <= hex_next;
        end
    end

endmodule

// File: tb/tb_hex_msg_scroller.sv
// Directed bench for hex_msg_scroller with a 4-cycle scroll period and active-low outputs.
module tb_hex_msg_scroller;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        pause;
    logic        dir;
    logic [4:0]  msg_len;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [6:0]  wr_data;
    logic [41:0] hex_out;
    logic        wrap;

    int checks = 0;
    int errors = 0;

    localparam logic [41:0] ALL_BLANK = 42'h3FF_FFFF_FFFF;
    localparam logic [6:0] NH = 7'h09;
    localparam logic [6:0] NE = 7'h06;
    localparam logic [6:0] NL = 7'h47;
    localparam logic [6:0] NO = 7'h40;
    localparam logic [6:0] ND = 7'h21;

    hex_msg_scroller #(
        .NUM_DIGITS (6),
        .MSG_DEPTH  (16),
        .TICK_DIV   (4),
        .ACTIVE_LOW (1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .pause   (pause),
        .dir     (dir),
        .msg_len (msg_len),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .hex_out (hex_out),
        .wrap    (wrap)
    );

    always #5 clk = ~clk;

    // Advance n clock edges and settle 1 time unit past the last one.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic writeMsg(input logic [3:0] addr, input logic [6:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        applyStimulus(1);
        wr_en   = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    function automatic logic [6:0] digit(input int k);
        return hex_out[(5-k)*7 +: 7];
    endfunction

    initial begin
        reset = 1'b1; en = 1'b0; pause = 1'b0; dir = 1'b0; msg_len = 5'd0;
        wr_en = 1'b0; wr_addr = 4'd0; wr_data = 7'h00;
        applyStimulus(2);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(1);
            checkOutput("idle_hex", 64'(hex_out), 64'(ALL_BLANK));
            checkOutput("idle_wrap", 64'(wrap), 64'd0);
        end

        msg_len = 5'd5;
        writeMsg(4'd0, 7'h76);
        writeMsg(4'd1, 7'h79);
        writeMsg(4'd2, 7'h38);
        writeMsg(4'd3, 7'h38);
        writeMsg(4'd4, 7'h3F);
        applyStimulus(1);
        checkOutput("hello_pos0", 64'(hex_out), 64'({NH, NE, NL, NL, NO, NH}));

        en = 1'b1;
        applyStimulus(4);
        checkOutput("pre_step_d0", 64'(digit(0)), 64'(NE) ^ 64'(NE ^ NH));
        applyStimulus(1);
        checkOutput("step1_hex", 64'(hex_out), 64'({NE, NL, NL, NO, NH, NE}));
        applyStimulus(3);
        checkOutput("step2_early", 64'(digit(0)), 64'(NE));
        applyStimulus(1);
        checkOutput("step2_d0", 64'(digit(0)), 64'(NL));
        for (int t = 10; t <= 21; t++) begin
            applyStimulus(1);
            checkOutput($sformatf("left_wrap_t%0d", t), 64'(wrap), (t == 20) ? 64'd1 : 64'd0);
        end
        checkOutput("left_back_d0", 64'(digit(0)), 64'(NH));

        en = 1'b0;
        applyStimulus(1);
        dir = 1'b1;
        en  = 1'b1;
        applyStimulus(3);
        checkOutput("right_nowrap", 64'(wrap), 64'd0);
        applyStimulus(1);
        checkOutput("right_wrap", 64'(wrap), 64'd1);
        applyStimulus(1);
        checkOutput("right_wrap_end", 64'(wrap), 64'd0);
        checkOutput("right_hex", 64'(hex_out), 64'({NO, NH, NE, NL, NL, NO}));
        checkOutput("right_d1", 64'(digit(1)), 64'(NH));

        applyStimulus(1);
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1);
            checkOutput("pause_hold", 64'({wrap, digit(0)}), 64'({1'b0, NO}));
        end
        pause = 1'b0;
        applyStimulus(2);
        checkOutput("resume_early", 64'(digit(0)), 64'(NO));
        applyStimulus(1);
        checkOutput("resume_step", 64'(digit(0)), 64'(NL));

        dir = 1'b0;
        applyStimulus(3);
        en = 1'b0;
        applyStimulus(1);
        checkOutput("at_pos4_d0", 64'(digit(0)), 64'(NO));
        msg_len = 5'd3;
        applyStimulus(1);
        checkOutput("shrink_wrap", 64'(wrap), 64'd0);
        applyStimulus(1);
        checkOutput("shrink_hex", 64'(hex_out), 64'({NH, NE, NL, NH, NE, NL}));
        checkOutput("shrink_wrap2", 64'(wrap), 64'd0);

        msg_len = 5'd0;
        applyStimulus(2);
        checkOutput("len0_hex", 64'(hex_out), 64'(ALL_BLANK));

        msg_len = 5'd5;
        applyStimulus(2);
        checkOutput("len5_restore", 64'(hex_out), 64'({NH, NE, NL, NL, NO, NH}));
        en = 1'b1;
        applyStimulus(1);
        writeMsg(4'd0, 7'h5E);
        checkOutput("write_early", 64'(digit(0)), 64'(NH));
        applyStimulus(1);
        checkOutput("write_visible", 64'(hex_out), 64'({ND, NE, NL, NL, NO, ND}));
        applyStimulus(1);
        checkOutput("write_pre_step", 64'(digit(0)), 64'(ND));
        applyStimulus(1);
        checkOutput("write_step", 64'(digit(0)), 64'(NE));

        reset = 1'b1;
        applyStimulus(1);
        reset = 1'b0;
        checkOutput("midreset_hex", 64'(hex_out), 64'(ALL_BLANK));
        applyStimulus(1);
        checkOutput("midreset_buf", 64'({wrap, hex_out}), 64'({1'b0, ALL_BLANK}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hex_msg_scroller.md
Name: hex_msg_scroller

Overview:
- Parametrised successor to the fixed-message letter lookup.
- Holds a writable message buffer of 7-segment codes and scrolls it across NUM_DIGITS HEX displays at a programmable rate.
- Supports left and right scrolling, pause, and an active-low output option.
- Sits between the board-level HEX pins and any user logic that loads message text.

Parameters:
- NUM_DIGITS, 6: number of HEX displays driven.
- MSG_DEPTH, 16: message buffer entries; must be a power of 2 and at least 2.
- TICK_DIV, 12500000: clock cycles per scroll step (4 Hz at 50 MHz); must be at least 2.
- ACTIVE_LOW, 1: 1 = segment outputs inverted for DE-board HEX pins.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  scroll enable; 0 clears the prescaler and holds the position.
- pause  in  1  freezes both the prescaler and the position, without clearing.
- dir  in  1  0 = scroll left (text moves toward HEX0-side start), 1 = scroll right.
- msg_len  in  $clog2(MSG_DEPTH)+1  active message length, 0..MSG_DEPTH.
- wr_en  in  1  buffer write strobe.
- wr_addr  in  $clog2(MSG_DEPTH)  buffer write address.
- wr_data  in  7  segment code, active-high, bit0 = segment a.
- hex_out  out  7*NUM_DIGITS  digit 0 (leftmost) in the MSBs, digit NUM_DIGITS-1 in bits [6:0].
- wrap  out  1  one-cycle pulse when the position wraps.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (port reset). It has priority over all other inputs.
- Reset values:
  - All buffer entries = 7'h00 (blank).
  - Position pos = 0; prescaler = 0; wrap = 0.
  - hex_out = all blank: all ones if ACTIVE_LOW=1, else all zeros.
- Buffer write: on wr_en, msg[wr_addr] <= wr_data. Writes are legal at any time, including while scrolling.
- Prescaler:
  - When en=1 and pause=0, it counts 0..TICK_DIV-1.
  - A step occurs on the cycle it equals TICK_DIV-1; the prescaler then returns to 0.
  - pause=1 holds both prescaler and pos.
  - en=0 forces the prescaler to 0 and holds pos. pause is ignored while en=0.
- Step, dir=0: pos <= (pos == msg_len-1) ? 0 : pos+1. wrap pulses when the step takes pos to 0.
- Step, dir=1: pos <= (pos == 0) ? msg_len-1 : pos-1. wrap pulses when the step takes pos from 0 to msg_len-1.
- Changing dir between steps is legal and takes effect on the next step.
- Digit indexing:
  - Digit k shows msg[idx_k], with idx_0 = pos and idx_{k+1} = (idx_k+1 == msg_len) ? 0 : idx_k+1.
  - When msg_len < NUM_DIGITS, the message therefore repeats across the display.
- msg_len = 0: all digits blank, pos forced to 0, no steps, no wrap.
- msg_len = 1: every step keeps pos = 0 and pulses wrap.
- msg_len shrink: if pos >= msg_len, pos <= 0 on the next cycle, with no wrap pulse. This correction overrides a coincident step.
- msg_len > MSG_DEPTH is illegal; the bench must not drive it. RTL clamps it to MSG_DEPTH.
- Output timing:
  - hex_out is registered and recomputed every cycle from the current pos, msg_len and buffer.
  - Latency is 1 cycle from a pos change or a buffer write to a visible hex_out change.
  - ACTIVE_LOW inversion is applied at the output register.
- Simultaneous write and step: both occur. The written value appears in hex_out one cycle after the write.
- Reset mid-scroll: everything returns to reset values on the next edge. Buffer contents are lost.

Decomposition:
- Package hex_msg_pkg:
  - Segment code constants: SEG_H=7'h76, SEG_E=7'h79, SEG_L=7'h38, SEG_O=7'h3F, SEG_U=7'h3E, SEG_R=7'h50, SEG_D=7'h5E, SEG_BLANK=7'h00.
  - A function for the blank output value given ACTIVE_LOW.
- Sub-module hex_scroll_tick: the prescaler, with inputs en/pause and a one-cycle step output.
- Buffer, position logic and the output mux stay in the top module.

Test Plan:
All scenarios use NUM_DIGITS=6, MSG_DEPTH=16, TICK_DIV=4.
1. Reset, then idle -> hex_out = 42'h3FF_FFFF_FFFF (all ones), wrap=0, for 10 cycles.
2. Load "HELLO" (76,79,38,38,3F) and set msg_len=5, en=1, dir=0:
   - Digit0 shows ~76 before the first step and ~79 after it.
   - Steps occur every 4 cycles.
   - On the 5th step pos returns to 0 and wrap pulses for exactly 1 cycle.
3. Same message with dir=1 -> the first step gives pos=4 with a wrap pulse; digit0 = ~3F, digit1 = ~76.
4. Assert pause for 10 cycles mid-count, then release -> no step during pause; the remaining prescaler count completes the interrupted period.
5. pos=4 with msg_len=5, then set msg_len=3 -> pos=0 the next cycle, no wrap; digits show H,E,L,H,E,L.
6. Write msg[0]=SEG_D while pos=0 and scrolling -> digit0 = ~5E exactly 1 cycle later; the step count is undisturbed.
